// File: rtl/led_breather.sv
// LED breathing controller: ramps a brightness level up and down on prescaler strobes,
// holds at each extreme, and drives a registered PWM pin from a period-aligned duty shadow.
module led_breather #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned HOLD_STEPS = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                en,
  input  logic                step,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic [2:0]          phase,
  output logic                busy
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRampUp   = 3'd1,
    StHoldHigh = 3'd2,
    StRampDown = 3'd3,
    StHoldLow  = 3'd4
  } state_e;

  localparam logic [PWM_BITS-1:0] LevelMax     = '1;
  localparam logic [PWM_BITS-1:0] LevelNearMax = LevelMax - 1'b1;
  localparam logic [PWM_BITS-1:0] LevelOne     = 1;
  localparam logic [7:0]          HoldLast     = 8'(HOLD_STEPS - 1);

  state_e              state_q;
  logic [PWM_BITS-1:0] level_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [7:0]          hold_cnt_q;
  logic                busy_q;
  logic                led_q;

  // Breathing FSM; en low overrides everything, including a coincident step.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      level_q    <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else if (!en) begin
      state_q    <= StIdle;
      level_q    <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q    <= StRampUp;
          level_q    <= '0;
          hold_cnt_q <= '0;
          busy_q     <= 1'b1;
        end
        StRampUp: begin
          if (step && (level_q != LevelMax)) begin
            level_q <= level_q + 1'b1;
            if (level_q == LevelNearMax) begin
              state_q    <= StHoldHigh;
              hold_cnt_q <= '0;
            end
          end
        end
        StHoldHigh: begin
          if (step) begin
            if (hold_cnt_q == HoldLast) begin
              state_q    <= StRampDown;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + 8'd1;
            end
          end
        end
        StRampDown: begin
          if (step && (level_q != '0)) begin
            level_q <= level_q - 1'b1;
            if (level_q == LevelOne) begin
              state_q    <= StHoldLow;
              hold_cnt_q <= '0;
            end
          end
        end
        StHoldLow: begin
          if (step) begin
            if (hold_cnt_q == HoldLast) begin
              state_q    <= StRampUp;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          level_q    <= '0;
          hold_cnt_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Free-running PWM; duty only reloads on the last count so no period is cut short.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      led_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (pwm_cnt_q == LevelMax) begin
        duty_q <= level_q;
      end
      led_q <= (pwm_cnt_q < duty_q) && (state_q != StIdle);
    end
  end

  assign led   = led_q;
  assign level = level_q;
  assign phase = state_q;
  assign busy  = busy_q;

endmodule
